// File: rtl/delay_sched.sv
// Round-robin shared delay timer: one requester at a time owns a counter that runs 0..lim.
// Optional abort/abt ports and cancel behaviour are enabled by defining DELAY_SCHED_ABORT_EN.
module delay_sched #(
  parameter int NREQ    = 4,
  parameter int CBITS   = 15,
  parameter int MAX_LEN = 22500
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*CBITS-1:0] len,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic                  busy,
  output logic [CBITS-1:0]      cnt,
  output logic                  err
`ifdef DELAY_SCHED_ABORT_EN
  ,
  input  logic                  abort,
  output logic                  abt
`endif
);

  localparam int PBITS = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [CBITS-1:0] MAX_LIM = CBITS'(MAX_LEN);
  localparam logic [PBITS-1:0] PTR_RST = PBITS'(NREQ - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           r_state, w_state;
  logic [NREQ-1:0]  r_own, w_own;
  logic [CBITS-1:0] r_cnt, w_cnt;
  logic [CBITS-1:0] r_lim, w_lim;
  logic             r_err, w_err;
  logic [PBITS-1:0] r_ptr, w_ptr;
`ifdef DELAY_SCHED_ABORT_EN
  logic             r_abt, w_abt;
`endif

  logic [CBITS-1:0] w_len_arr [NREQ];
  logic             w_found;
  logic [PBITS-1:0] w_cand;
  logic [PBITS-1:0] w_win_idx;
  logic [NREQ-1:0]  w_win_oh;
  logic [CBITS-1:0] w_win_len;

  for (genvar g = 0; g < NREQ; g++) begin : g_len
    assign w_len_arr[g] = len[g*CBITS +: CBITS];
  end

  // Search order starts just past the last winner, so the last owner is considered last.
  always_comb begin
    w_found   = 1'b0;
    w_cand    = '0;
    w_win_idx = '0;
    w_win_oh  = '0;
    w_win_len = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_cand = PBITS'((int'(r_ptr) + k) % NREQ);
      if (!w_found && req[w_cand]) begin
        w_found          = 1'b1;
        w_win_idx        = w_cand;
        w_win_oh         = '0;
        w_win_oh[w_cand] = 1'b1;
        w_win_len        = w_len_arr[w_cand];
      end
    end
  end

  always_comb begin
    w_state = r_state;
    w_own   = r_own;
    w_cnt   = r_cnt;
    w_lim   = r_lim;
    w_err   = r_err;
    w_ptr   = r_ptr;
`ifdef DELAY_SCHED_ABORT_EN
    w_abt   = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        w_cnt = '0;
        if (w_found) begin
          w_state = RUN;
          w_own   = w_win_oh;
          w_ptr   = w_win_idx;
          if (w_win_len > MAX_LIM) begin
            w_lim = MAX_LIM;
            w_err = 1'b1;
          end else begin
            w_lim = w_win_len;
          end
        end
      end
      RUN: begin
`ifdef DELAY_SCHED_ABORT_EN
        if (abort) begin
          w_state = IDLE;
          w_own   = '0;
          w_cnt   = '0;
          w_abt   = 1'b1;
        end else
`endif
        if (r_cnt == r_lim) begin
          w_state = DONE;
          w_cnt   = '0;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      DONE: begin
        w_state = IDLE;
        w_own   = '0;
        w_cnt   = '0;
      end
      default: begin
        w_state = IDLE;
        w_own   = '0;
        w_cnt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_own   <= '0;
      r_cnt   <= '0;
      r_lim   <= '0;
      r_err   <= 1'b0;
      r_ptr   <= PTR_RST;
`ifdef DELAY_SCHED_ABORT_EN
      r_abt   <= 1'b0;
`endif
    end else begin
      r_state <= w_state;
      r_own   <= w_own;
      r_cnt   <= w_cnt;
      r_lim   <= w_lim;
      r_err   <= w_err;
      r_ptr   <= w_ptr;
`ifdef DELAY_SCHED_ABORT_EN
      r_abt   <= w_abt;
`endif
    end
  end

  // Owner bits drive gnt while running and done for the single completion cycle.
  assign gnt  = (r_state == RUN)  ? r_own : '0;
  assign done = (r_state == DONE) ? r_own : '0;
  assign busy = (r_state == RUN);
  assign cnt  = r_cnt;
  assign err  = r_err;
`ifdef DELAY_SCHED_ABORT_EN
  assign abt  = r_abt;
`endif

endmodule

// File: tb/tb_delay_sched.sv
// Scoreboard bench for delay_sched: each issued grant pushes {done vector, grant length};
// a negedge monitor pops on every done pulse. Abort cases run when DELAY_SCHED_ABORT_EN is defined.
module tb_delay_sched;
  localparam int NREQ  = 4;
  localparam int CBITS = 15;
  localparam int EW    = NREQ + 16;

  logic                  clk;
  logic                  rst;
  logic [NREQ-1:0]       req;
  logic [NREQ*CBITS-1:0] len;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       done;
  logic                  busy;
  logic [CBITS-1:0]      cnt;
  logic                  err;
`ifdef DELAY_SCHED_ABORT_EN
  logic                  abort;
  logic                  abt;
`endif

  logic [EW-1:0] exp_q[$];
  int            done_times[$];
  int            n_vec;
  int            n_err;
  int            cyc;
  logic [15:0]   run_len;
  logic [NREQ-1:0] run_own;

  delay_sched #(.NREQ(NREQ), .CBITS(CBITS), .MAX_LEN(22500)) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .len  (len),
    .gnt  (gnt),
    .done (done),
    .busy (busy),
    .cnt  (cnt),
    .err  (err)
`ifdef DELAY_SCHED_ABORT_EN
    ,
    .abort(abort),
    .abt  (abt)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: sim time expired, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // driver tasks
  task automatic set_len(input int i, input int v);
    len[i*CBITS +: CBITS] = CBITS'(v);
  endtask

  task automatic pulse_req(input logic [NREQ-1:0] r);
    @(negedge clk);
    req = r;
    @(negedge clk);
    req = '0;
  endtask

  task automatic expect_grant(input logic [NREQ-1:0] oh, input int cycles);
    exp_q.push_back({oh, 16'(cycles)});
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy || done != '0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_queue", 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_cnt(input logic [CBITS-1:0] v, input int budget);
    int n;
    n = 0;
    while (!(busy && cnt == v) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("wait_cnt_reached", 32'(cnt), 32'(v));
  endtask

  // scoreboard monitor
  initial begin
    run_len = '0;
    run_own = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (busy) begin
          if (run_len == 16'd0) run_own = gnt;
          else check("gnt_hold", 32'(gnt), 32'(run_own));
          check("cnt_seq", 32'(cnt), 32'(run_len));
          run_len = run_len + 16'd1;
        end else begin
          check("gnt_zero_when_idle", 32'(gnt), 32'd0);
          if (done != '0) begin
            if (exp_q.size() == 0) begin
              check("unexpected_done", 32'(done), 32'd0);
            end else begin
              check("done_owner_len", 32'({done, run_len}), 32'(exp_q.pop_front()));
            end
            done_times.push_back(cyc);
          end
          run_len = '0;
        end
      end
    end
  end

  initial begin
    int b;
    n_vec = 0;
    n_err = 0;
    rst   = 1'b1;
    req   = '0;
    len   = '0;
`ifdef DELAY_SCHED_ABORT_EN
    abort = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cnt", 32'(cnt), 32'd0);
    check("rst_err", 32'(err), 32'd0);

    // single request, len 3: four grant cycles
    set_len(0, 3);
    expect_grant(4'b0001, 4);
    pulse_req(4'b0001);
    check("single_gnt_t1", 32'(gnt), 32'h1);
    drain(50);

    // idle with no request
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_cnt", 32'(cnt), 32'd0);

    // zero length on requester 2
    set_len(2, 0);
    expect_grant(4'b0100, 1);
    pulse_req(4'b0100);
    check("zero_gnt_t1", 32'(gnt), 32'h4);
    @(negedge clk);
    check("zero_done_t2", 32'(done), 32'h4);
    drain(50);

    // fairness from reset: 0,1,2,3,0 each len 1
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) set_len(i, 1);
    expect_grant(4'b0001, 2);
    expect_grant(4'b0010, 2);
    expect_grant(4'b0100, 2);
    expect_grant(4'b1000, 2);
    expect_grant(4'b0001, 2);
    b = done_times.size();
    req = 4'b1111;
    for (int n = 0; n < 100 && done_times.size() < b + 5; n++) @(negedge clk);
    req = '0;
    check("fair_done_count", 32'(done_times.size() - b), 32'd5);
    for (int i = 1; i < 5; i++)
      if (done_times.size() > b + i)
        check("fair_done_spacing", 32'(done_times[b+i] - done_times[b+i-1]), 32'd4);
    drain(50);

    // clamp: 30000 exceeds the maximum, runs 22501 cycles with err sticky
    set_len(1, 30000);
    expect_grant(4'b0010, 22501);
    pulse_req(4'b0010);
    check("clamp_err_t1", 32'(err), 32'd1);
    drain(23000);
    check("clamp_err_held", 32'(err), 32'd1);

    // reset mid-run at cnt 10
    set_len(0, 20);
    pulse_req(4'b0001);
    wait_cnt(15'd10, 50);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_gnt", 32'(gnt), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_cnt", 32'(cnt), 32'd0);
    check("midrst_err", 32'(err), 32'd0);
    repeat (3) @(negedge clk);
    set_len(0, 2);
    set_len(1, 2);
    expect_grant(4'b0001, 3);
    pulse_req(4'b0011);
    check("midrst_first_winner", 32'(gnt), 32'h1);
    drain(50);

`ifdef DELAY_SCHED_ABORT_EN
    // abort at cnt 2 of len 5; pending requester 1 follows after one idle cycle
    set_len(0, 5);
    set_len(1, 1);
    pulse_req(4'b0001);
    wait_cnt(15'd2, 20);
    expect_grant(4'b0010, 2);
    abort = 1'b1;
    req   = 4'b0010;
    @(negedge clk);
    abort = 1'b0;
    check("abort_abt", 32'(abt), 32'd1);
    check("abort_gnt", 32'(gnt), 32'd0);
    check("abort_cnt", 32'(cnt), 32'd0);
    @(negedge clk);
    check("abort_abt_pulse", 32'(abt), 32'd0);
    check("abort_next_grant", 32'(gnt), 32'h2);
    req = '0;
    drain(50);
`endif

    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/delay_sched.md
DELAY_SCHED -- requirements
Module: delay_sched

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing the delay timer.
REQ-002 Parameter CBITS, default 15: timer and length width.
REQ-003 Parameter MAX_LEN, default 22500: largest permitted delay length.
REQ-004 Clocking and reset SHALL be: one clock; reset is synchronous and active-high.
REQ-005 Port list (name, direction, width, meaning):
- clk, input, 1: sole clock; all state updates on its rising edge.
- rst, input, 1: synchronous active-high reset.
- req, input, NREQ: per-requester delay request, level.
- len, input, NREQ*CBITS: per-requester delay length; slice i is len[i*CBITS +: CBITS].
- gnt, output, NREQ: one-hot owner of the timer; all zero when idle.
- done, output, NREQ: one-cycle completion pulse to the owner.
- busy, output, 1: timer is owned.
- cnt, output, CBITS: current timer value.
- err, output, 1: sticky flag, length out of range.
- abort, input, 1: cancel the current delay; present only with DELAY_SCHED_ABORT_EN.
- abt, output, 1: one-cycle abort acknowledge; present only with DELAY_SCHED_ABORT_EN.

Function
REQ-006 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-007 IDLE with req nonzero at edge t:
- Winner is chosen round-robin, searching from index ptr+1 modulo NREQ upward.
- At t+1: state is RUN, gnt has only the winner's bit set, cnt=0, lim is latched from the winner's len slice, and ptr is set to the winner's index.
REQ-008 IDLE with req zero: the block SHALL stay in IDLE with gnt=0, busy=0 and cnt held at 0.
REQ-009 RUN with cnt != lim: cnt SHALL increment by 1 per cycle and gnt SHALL hold.
REQ-010 RUN with cnt == lim: next state SHALL be DONE.
REQ-011 DONE (exactly one cycle):
- done has only the winner's bit set; gnt=0; busy=0; cnt resets to 0.
- Next state is IDLE.
- Arbitration is not performed in DONE, so there is always at least one IDLE cycle between grants.
REQ-012 Timing for length L:
- gnt is high for L+1 cycles (t+1 to t+L+1).
- done pulses at t+L+2.
- L=0 gives one RUN cycle with done at t+2.
REQ-013 If the latched len exceeds MAX_LEN, lim SHALL be clamped to MAX_LEN and err SHALL be set and held until reset.
REQ-014 cnt SHALL never exceed lim and SHALL never wrap, because MAX_LEN < 2^CBITS is required.
REQ-015 req and len changes during RUN SHALL be ignored. Deasserting the owner's req does not cancel the delay.
REQ-016 A requester still asserting req after its done SHALL be considered again in IDLE, after all other pending requesters in round-robin order.
REQ-017 busy SHALL equal (state == RUN), and gnt SHALL be zero whenever busy is 0.
REQ-018 Simultaneous requests: lowest index after ptr wins; the others wait without loss.

Reset
REQ-019 When rst=1 at an edge, the next state SHALL be IDLE with gnt=0, done=0, busy=0, cnt=0, lim=0, err=0, abt=0 and ptr=NREQ-1, so that req[0] has first priority.
REQ-020 Reset SHALL take priority over every other condition, including during RUN and DONE. A delay in progress is dropped and no done pulse is issued.

Configuration
REQ-021 With macro DELAY_SCHED_ABORT_EN defined, abort and abt SHALL exist, and abort=1 sampled in RUN SHALL cause:
- next state IDLE, gnt=0, cnt=0;
- abt pulsed for one cycle;
- no done pulse;
- ptr retained, so the aborted requester loses its turn.
REQ-022 With DELAY_SCHED_ABORT_EN defined, abort SHALL be ignored in IDLE and DONE, and abort SHALL take priority over cnt == lim in RUN.
REQ-023 Without DELAY_SCHED_ABORT_EN, the abort and abt ports SHALL be absent and every grant SHALL run to completion.

Verification
REQ-024 Single request: req=0001, len[0]=3 at t -> gnt=0001 for t+1..t+4; done=0001 at t+5; cnt counts 0,1,2,3.
REQ-025 Zero length: req=0100, len[2]=0 -> gnt=0100 at t+1 only; done=0100 at t+2.
REQ-026 Fairness: req=1111 held, all len=1 -> grant order 0,1,2,3,0; every done separated by 4 cycles.
REQ-027 Clamp: len[1]=30000 -> err=1 from t+1 and held; done at t+1+22500+1.
REQ-028 Reset mid-run: rst=1 while cnt=10 -> next cycle all outputs 0, no done pulse; the next req=0001 wins first.
REQ-029 Abort (DELAY_SCHED_ABORT_EN defined): abort=1 at cnt=2 with len=5 -> abt=1 and gnt=0 next cycle, done never pulses; a pending req[1] is granted after one IDLE cycle.
